// File: rtl/half_pkg.sv
// Shared types and constants for the binary16 multiplier pipeline.
//   half_t     : sign/exponent/fraction view of one binary16 value
//   flags_t    : per-lane exception flags {invalid, overflow, underflow}
//   rnd_mode_t : RNE (round-to-nearest-even) or RTZ (truncate)
//   s1_t, s2_t : per-lane payloads carried between pipeline stages
package half_pkg;

    localparam int unsigned HALF_W   = 16;
    localparam int unsigned FLAG_W   = 3;
    localparam int          EXP_BIAS = 15;
    localparam int          EXP_MAX  = 31;

    localparam logic [15:0] QNAN       = 16'h7E00;
    localparam logic [15:0] POS_INF    = 16'h7C00;
    localparam logic [15:0] MAX_FINITE = 16'h7BFF;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] frac;
    } half_t;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
    } flags_t;

    typedef enum logic {
        RNE = 1'b0,
        RTZ = 1'b1
    } rnd_mode_t;

    // After S1: classification result plus raw exponent sum and mantissa product.
    typedef struct packed {
        rnd_mode_t   rnd;
        logic        special;
        logic [15:0] spec_val;
        flags_t      spec_flags;
        logic        sign;
        logic [7:0]  exp;       // two's complement biased exponent
        logic [21:0] prod;
    } s1_t;

    // After S2: normalised and rounded, range not yet checked.
    typedef struct packed {
        rnd_mode_t   rnd;
        logic        special;
        logic [15:0] spec_val;
        flags_t      spec_flags;
        logic        sign;
        logic [7:0]  exp;       // two's complement biased exponent
        logic [9:0]  frac;
    } s2_t;

endpackage

// File: rtl/half_mul_lane.sv
// One binary16 multiply lane. All registers advance together on en.
//   clk, rst   : clock, asynchronous active-high reset
//   en         : global stage enable (stall when low)
//   rnd_mode   : 0 = RNE, 1 = RTZ, captured with the operands
//   a, b       : binary16 operands
//   c, flags   : registered product and exception flags
// Register stages: S1 (unpack/product), STAGES-3 retiming copies of S1,
// S2 (normalise/round, omitted when STAGES=2), S3 (pack/flags, output).
module half_mul_lane
    import half_pkg::*;
#(
    parameter int unsigned STAGES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        rnd_mode,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] c,
    output flags_t      flags
);

    localparam int unsigned RETIME = (STAGES > 3) ? STAGES - 3 : 0;

    half_t ha, hb;
    s1_t   s1_d, s1_q;
    s1_t   s1_chain [RETIME+1];
    s2_t   s2_d, s2_q;
    logic [15:0] c_d, c_q;
    flags_t      f_d, f_q;

    assign ha = a;
    assign hb = b;

    // S1: unpack, classify, exponent sum, mantissa product
    always_comb begin
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        s1_d   = '0;
        a_nan  = (ha.exp == 5'd31) && (ha.frac != '0);
        b_nan  = (hb.exp == 5'd31) && (hb.frac != '0);
        a_inf  = (ha.exp == 5'd31) && (ha.frac == '0);
        b_inf  = (hb.exp == 5'd31) && (hb.frac == '0);
        // flush-to-zero: any zero exponent is a signed zero
        a_zero = (ha.exp == 5'd0);
        b_zero = (hb.exp == 5'd0);

        s1_d.rnd  = rnd_mode_t'(rnd_mode);
        s1_d.sign = ha.sign ^ hb.sign;
        s1_d.exp  = {3'b0, ha.exp} + {3'b0, hb.exp} - 8'(EXP_BIAS);
        s1_d.prod = {1'b1, ha.frac} * {1'b1, hb.frac};

        if (a_nan || b_nan) begin
            s1_d.special  = 1'b1;
            s1_d.spec_val = QNAN;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            s1_d.special            = 1'b1;
            s1_d.spec_val           = QNAN;
            s1_d.spec_flags.invalid = 1'b1;
        end else if (a_inf || b_inf) begin
            s1_d.special  = 1'b1;
            s1_d.spec_val = POS_INF | {s1_d.sign, 15'b0};
        end else if (a_zero || b_zero) begin
            s1_d.special  = 1'b1;
            s1_d.spec_val = {s1_d.sign, 15'b0};
        end
    end

    // S1 register followed by retiming copies on the product path
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= RETIME; i++) begin
                s1_chain[i] <= '0;
            end
        end else if (en) begin
            s1_chain[0] <= s1_d;
            for (int i = 1; i <= RETIME; i++) begin
                s1_chain[i] <= s1_chain[i-1];
            end
        end
    end

    assign s1_q = s1_chain[RETIME];

    // S2: normalise, round
    always_comb begin
        logic        hi, guard, sticky, round_up;
        logic [10:0] mant;
        logic [11:0] mant_r;
        logic [7:0]  exp_n;
        s2_d            = '0;
        s2_d.rnd        = s1_q.rnd;
        s2_d.special    = s1_q.special;
        s2_d.spec_val   = s1_q.spec_val;
        s2_d.spec_flags = s1_q.spec_flags;
        s2_d.sign       = s1_q.sign;

        hi     = s1_q.prod[21];   // product in [2,4)
        mant   = hi ? s1_q.prod[21:11] : s1_q.prod[20:10];
        guard  = hi ? s1_q.prod[10] : s1_q.prod[9];
        sticky = hi ? (|s1_q.prod[9:0]) : (|s1_q.prod[8:0]);
        exp_n  = s1_q.exp + {7'b0, hi};

        round_up = (s1_q.rnd == RNE) && guard && (sticky || mant[0]);
        mant_r   = {1'b0, mant} + {11'b0, round_up};

        if (mant_r[11]) begin
            // 1.11..1 rounded up to 10.0: renormalise
            s2_d.frac = mant_r[10:1];
            s2_d.exp  = exp_n + 8'd1;
        end else begin
            s2_d.frac = mant_r[9:0];
            s2_d.exp  = exp_n;
        end
    end

    if (STAGES >= 3) begin : g_s2_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_q <= '0;
            end else if (en) begin
                s2_q <= s2_d;
            end
        end
    end else begin : g_s2_merged
        assign s2_q = s2_d;
    end

    // S3: range check, pack, flags
    always_comb begin
        c_d = '0;
        f_d = '0;
        if (s2_q.special) begin
            c_d = s2_q.spec_val;
            f_d = s2_q.spec_flags;
        end else if ($signed(s2_q.exp) >= $signed(8'(EXP_MAX))) begin
            f_d.overflow = 1'b1;
            c_d = ((s2_q.rnd == RNE) ? POS_INF : MAX_FINITE) | {s2_q.sign, 15'b0};
        end else if ($signed(s2_q.exp) <= $signed(8'd0)) begin
            f_d.underflow = 1'b1;
            c_d = {s2_q.sign, 15'b0};
        end else begin
            c_d = {s2_q.sign, s2_q.exp[4:0], s2_q.frac};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q <= '0;
            f_q <= '0;
        end else if (en) begin
            c_q <= c_d;
            f_q <= f_d;
        end
    end

    assign c     = c_q;
    assign flags = f_q;

endmodule

// File: rtl/half_multiply_pipe.sv
// Multi-lane pipelined binary16 multiplier with valid/ready handshake.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid, in_ready   : operand beat handshake (in_ready = !out_valid || out_ready)
//   rnd_mode             : 0 = RNE, 1 = RTZ, travels with the beat
//   a, b                 : LANES packed binary16 operands, lane i at [16i+15:16i]
//   out_valid, out_ready : result beat handshake
//   c                    : LANES packed binary16 products
//   flags                : per lane {invalid, overflow, underflow} at [3i+2:3i]
// Fixed latency of STAGES register stages; any stall freezes the whole pipe.
module half_multiply_pipe
    import half_pkg::*;
#(
    parameter int unsigned LANES  = 4,
    parameter int unsigned STAGES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    rnd_mode,
    input  logic [LANES*16-1:0]     a,
    input  logic [LANES*16-1:0]     b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*16-1:0]     c,
    output logic [LANES*FLAG_W-1:0] flags
);

    logic [STAGES-1:0] valid_q;
    logic              en;

    assign out_valid = valid_q[STAGES-1];
    assign in_ready  = !out_valid || out_ready;
    // Global stall: nothing moves unless the output slot can drain.
    assign en        = in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (en) begin
            valid_q <= {valid_q[STAGES-2:0], in_valid};
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        half_mul_lane #(
            .STAGES(STAGES)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .rnd_mode (rnd_mode),
            .a        (a[16*i +: 16]),
            .b        (b[16*i +: 16]),
            .c        (c[16*i +: 16]),
            .flags    (flags[FLAG_W*i +: FLAG_W])
        );
    end

endmodule

// File: tb/tb_half_multiply_pipe.sv
// Self-checking bench for half_multiply_pipe: directed vectors, backpressure,
// mid-stream reset and random traffic checked against a real-arithmetic model.
module tb_half_multiply_pipe;

    localparam int LANES  = 4;
    localparam int STAGES = 3;

    typedef logic [LANES*16-1:0] vec_t;
    typedef logic [LANES*3-1:0]  fvec_t;

    typedef struct {
        vec_t  c;
        fvec_t f;
        int    cyc;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  in_valid = 1'b0;
    logic  in_ready;
    logic  rnd_mode = 1'b0;
    vec_t  a = '0;
    vec_t  b = '0;
    logic  out_valid;
    logic  out_ready = 1'b1;
    vec_t  c;
    fvec_t flags;

    half_multiply_pipe #(
        .LANES  (LANES),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rnd_mode  (rnd_mode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    n_acc = 0;
    bit    chk_lat = 1'b0;
    bit    prev_stall = 1'b0;
    vec_t  prev_c;
    fvec_t prev_f;
    exp_t  sb[$];

    // ---------------- reference model ----------------
    function automatic real pow2(input int n);
        real r;
        r = 1.0;
        if (n >= 0) repeat (n) r = r * 2.0;
        else repeat (-n) r = r / 2.0;
        return r;
    endfunction

    function automatic void ref_mul(input logic [15:0] x, input logic [15:0] y, input bit rtz,
                                    output logic [15:0] r, output logic [2:0] f);
        int  ex, ey, fx, fy, e, ip, be;
        bit  s, xnan, ynan, xinf, yinf, xz, yz;
        real m, scaled, rem;
        ex = int'(x[14:10]); fx = int'(x[9:0]);
        ey = int'(y[14:10]); fy = int'(y[9:0]);
        s = x[15] ^ y[15];
        xnan = (ex == 31) && (fx != 0); ynan = (ey == 31) && (fy != 0);
        xinf = (ex == 31) && (fx == 0); yinf = (ey == 31) && (fy == 0);
        xz = (ex == 0); yz = (ey == 0);
        f = 3'b000;
        r = 16'h0000;
        if (xnan || ynan) begin
            r = 16'h7E00;
        end else if ((xinf && yz) || (yinf && xz)) begin
            r = 16'h7E00;
            f = 3'b100;
        end else if (xinf || yinf) begin
            r = {s, 15'h7C00};
        end else if (xz || yz) begin
            r = {s, 15'h0000};
        end else begin
            m = (1.0 + fx / 1024.0) * pow2(ex - 15) * (1.0 + fy / 1024.0) * pow2(ey - 15);
            e = 0;
            while (m >= pow2(e + 1)) e++;
            while (m < pow2(e)) e--;
            scaled = m / pow2(e - 10);           // in [1024, 2048)
            ip = $rtoi(scaled);
            rem = scaled - ip;
            if (!rtz && ((rem > 0.5) || (rem == 0.5 && (ip % 2) == 1))) ip++;
            if (ip == 2048) begin
                ip = 1024;
                e++;
            end
            be = e + 15;
            if (be >= 31) begin
                f = 3'b010;
                r = rtz ? {s, 15'h7BFF} : {s, 15'h7C00};
            end else if (be <= 0) begin
                f = 3'b001;
                r = {s, 15'h0000};
            end else begin
                r = {s, be[4:0], ip[9:0]};
            end
        end
    endfunction

    function automatic logic [15:0] rand_half();
        int sel;
        logic [15:0] v;
        sel = $urandom_range(0, 15);
        v = 16'($urandom);
        if (sel == 0) return v;
        if (sel == 1) begin
            case ($urandom_range(0, 3))
                0: return {v[15], 15'h0000};
                1: return {v[15], 15'h7C00};
                2: return {v[15], 5'd31, 10'h001 | v[9:0]};
                default: return {v[15], 5'd0, v[9:0]};
            endcase
        end
        return {v[15], 5'($urandom_range(3, 27)), v[9:0]};
    endfunction

    task automatic rand_beat(output vec_t av, output vec_t bv, output bit rm,
                             output vec_t ec, output fvec_t ef);
        logic [15:0] x, y, r;
        logic [2:0]  f;
        rm = 1'($urandom_range(0, 1));
        for (int i = 0; i < LANES; i++) begin
            x = rand_half();
            y = rand_half();
            ref_mul(x, y, rm, r, f);
            av[16*i +: 16] = x;
            bv[16*i +: 16] = y;
            ec[16*i +: 16] = r;
            ef[3*i +: 3] = f;
        end
    endtask

    // Lane i takes entry i%4 of a four-entry table.
    function automatic vec_t pack16(input logic [15:0] l0, input logic [15:0] l1,
                                    input logic [15:0] l2, input logic [15:0] l3);
        logic [15:0] t [4];
        vec_t v;
        t[0] = l0; t[1] = l1; t[2] = l2; t[3] = l3;
        for (int i = 0; i < LANES; i++) v[16*i +: 16] = t[i%4];
        return v;
    endfunction

    function automatic fvec_t pack3(input logic [2:0] l0, input logic [2:0] l1,
                                    input logic [2:0] l2, input logic [2:0] l3);
        logic [2:0] t [4];
        fvec_t v;
        t[0] = l0; t[1] = l1; t[2] = l2; t[3] = l3;
        for (int i = 0; i < LANES; i++) v[3*i +: 3] = t[i%4];
        return v;
    endfunction

    // ---------------- one clock of traffic ----------------
    // Drive on the falling edge, sample 1 ns later, score handshakes that the
    // next rising edge will complete.
    task automatic cycle(input bit iv, input vec_t av, input vec_t bv, input bit rm,
                         input bit ordy, input vec_t ec, input fvec_t ef);
        exp_t e;
        @(negedge clk);
        in_valid = iv; a = av; b = bv; rnd_mode = rm; out_ready = ordy;
        #1;
        cyc++;
        if (prev_stall) begin
            checks++;
            assert (out_valid === 1'b1 && c === prev_c && flags === prev_f)
            else begin
                errors++;
                $error("FAIL stall_hold: got v=%b c=%h f=%h want v=1 c=%h f=%h",
                       out_valid, c, flags, prev_c, prev_f);
            end
        end
        if (out_valid && !out_ready) begin
            checks++;
            assert (in_ready === 1'b0)
            else begin
                errors++;
                $error("FAIL in_ready_stall: got %b want 0", in_ready);
            end
        end
        if (out_valid === 1'b1 && out_ready) begin
            checks++;
            assert (sb.size() > 0)
            else begin
                errors++;
                $error("FAIL spurious_out: got c=%h with no beat expected", c);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                assert (c === e.c)
                else begin
                    errors++;
                    $error("FAIL product: got %h want %h", c, e.c);
                end
                checks++;
                assert (flags === e.f)
                else begin
                    errors++;
                    $error("FAIL flags: got %b want %b", flags, e.f);
                end
                if (chk_lat) begin
                    // STAGES samples after acceptance = STAGES-1 edges after the capture edge
                    checks++;
                    assert (cyc - e.cyc == STAGES)
                    else begin
                        errors++;
                        $error("FAIL latency: got %0d want %0d", cyc - e.cyc, STAGES);
                    end
                end
            end
        end
        if (in_valid && in_ready === 1'b1) begin
            e.c = ec; e.f = ef; e.cyc = cyc;
            sb.push_back(e);
            n_acc++;
        end
        prev_stall = out_valid && !out_ready;
        prev_c = c;
        prev_f = flags;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 100) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1, '0, '0);
            guard++;
        end
        checks++;
        assert (sb.size() == 0)
        else begin
            errors++;
            $error("FAIL drain_%s: got %0d beats outstanding want 0", tag, sb.size());
        end
    endtask

    task automatic directed(input vec_t av, input vec_t bv, input bit rm,
                            input vec_t ec, input fvec_t ef, input string tag);
        cycle(1'b1, av, bv, rm, 1'b1, ec, ef);
        drain(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vec_t  av, bv, ec;
        fvec_t ef;
        bit    rm;
        int    start, t, guard;

        // 1. Reset with in_valid high, then the first beat
        rst = 1'b1;
        in_valid = 1'b1;
        a = pack16(16'h3E00, 16'h3E00, 16'h3E00, 16'h3E00);
        b = a;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        assert (out_valid === 1'b0)
        else begin errors++; $error("FAIL rst_valid: got %b want 0", out_valid); end
        checks++;
        assert (c === '0)
        else begin errors++; $error("FAIL rst_c: got %h want 0", c); end
        checks++;
        assert (flags === '0)
        else begin errors++; $error("FAIL rst_flags: got %h want 0", flags); end
        in_valid = 1'b0;
        rst = 1'b0;

        chk_lat = 1'b1;
        directed(pack16(16'h3E00, 16'h3C00, 16'h3C00, 16'h3C00),
                 pack16(16'h3E00, 16'h3C00, 16'h3C00, 16'h3C00), 1'b0,
                 pack16(16'h4080, 16'h3C00, 16'h3C00, 16'h3C00), '0, "first");

        // 2. Rounding, RNE then RTZ
        av = pack16(16'hBE00, 16'h4000, 16'h58B0, 16'h0000);
        bv = pack16(16'hBE00, 16'hBE00, 16'hD978, 16'hBE00);
        directed(av, bv, 1'b0, pack16(16'h4080, 16'hC200, 16'hF669, 16'h8000), '0, "rne");
        directed(av, bv, 1'b1, pack16(16'h4080, 16'hC200, 16'hF668, 16'h8000), '0, "rtz");

        // 3. Exceptions
        av = pack16(16'h5CB0, 16'h7C00, 16'h1400, 16'h7E01);
        bv = pack16(16'h5CB0, 16'h0000, 16'h1400, 16'h3C00);
        directed(av, bv, 1'b0, pack16(16'h7C00, 16'h7E00, 16'h0000, 16'h7E00),
                 pack3(3'b010, 3'b100, 3'b001, 3'b000), "exc_rne");
        directed(av, bv, 1'b1, pack16(16'h7BFF, 16'h7E00, 16'h0000, 16'h7E00),
                 pack3(3'b010, 3'b100, 3'b001, 3'b000), "exc_rtz");

        // 4. Backpressure: 8 beats, out_ready low for cycles 3..6
        chk_lat = 1'b0;
        start = n_acc;
        t = 0;
        while ((n_acc - start < 8 || sb.size() > 0) && t < 100) begin
            rand_beat(av, bv, rm, ec, ef);
            cycle(n_acc - start < 8, av, bv, rm, !(t >= 3 && t <= 6), ec, ef);
            t++;
        end
        checks++;
        assert (n_acc - start == 8 && sb.size() == 0)
        else begin
            errors++;
            $error("FAIL backpressure: got %0d accepted %0d pending want 8 0",
                   n_acc - start, sb.size());
        end

        // 5. Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            rand_beat(av, bv, rm, ec, ef);
            cycle(1'b1, av, bv, rm, 1'b0, ec, ef);
        end
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++;
        assert (out_valid === 1'b0 && c === '0)
        else begin errors++; $error("FAIL mid_rst: got v=%b c=%h want 0 0", out_valid, c); end
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        prev_stall = 1'b0;
        repeat (6) cycle(1'b0, '0, '0, 1'b0, 1'b1, '0, '0);
        chk_lat = 1'b1;
        directed(pack16(16'h3E00, 16'h4000, 16'h58B0, 16'h1400),
                 pack16(16'h3E00, 16'hBE00, 16'hD978, 16'h1400), 1'b0,
                 pack16(16'h4080, 16'hC200, 16'hF669, 16'h0000),
                 pack3(3'b000, 3'b000, 3'b000, 3'b001), "post_rst");

        // 6a. Unstalled random stream: latency must stay fixed
        for (int i = 0; i < 40; i++) begin
            rand_beat(av, bv, rm, ec, ef);
            cycle(1'b1, av, bv, rm, 1'b1, ec, ef);
        end
        drain("stream");

        // 6b. 1000 random beats with random valid/ready
        chk_lat = 1'b0;
        start = n_acc;
        guard = 0;
        while (n_acc - start < 1000 && guard < 20000) begin
            rand_beat(av, bv, rm, ec, ef);
            cycle($urandom_range(0, 3) != 0, av, bv, rm, $urandom_range(0, 3) != 0, ec, ef);
            guard++;
        end
        checks++;
        assert (n_acc - start == 1000)
        else begin errors++; $error("FAIL random_count: got %0d want 1000", n_acc - start); end
        drain("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
